alu_64bit: RTL and testbench

ALU_64BIT -- requirements
Module: alu_64bit

---
 rtl/alu_64bit_pkg.sv | 25 ++
 rtl/alu_64bit_if.sv | 25 ++
 rtl/alu_64bit_core.sv | 83 ++++++++
 rtl/alu_64bit.sv | 47 ++++
 tb/tb_alu_64bit.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_64bit_pkg.sv
// Shared definitions for the 64-bit ALU: operand width and the 4-bit opcode map.
package alu_64bit_pkg;

  localparam int unsigned Width = 64;

  typedef enum logic [3:0] {
    OpAdd  = 4'b0000,
    OpSub  = 4'b0001,
    OpAnd  = 4'b0010,
    OpOr   = 4'b0011,
    OpXor  = 4'b0100,
    OpNor  = 4'b0101,
    OpNand = 4'b0110,
    OpXnor = 4'b0111,
    OpSll  = 4'b1000,
    OpSrl  = 4'b1001,
    OpSra  = 4'b1010,
    OpMul  = 4'b1011,
    OpRol  = 4'b1100,
    OpRor  = 4'b1101,
    OpDiv  = 4'b1110,
    OpSlt  = 4'b1111
  } alu_op_e;

endpackage

// File: rtl/alu_64bit_if.sv
// Operand/opcode bus into the ALU and registered result/flags coming back.
interface alu_64bit_if;
  import alu_64bit_pkg::*;

  logic             enable;
  logic [Width-1:0] A;
  logic [Width-1:0] B;
  logic [3:0]       sel;
  logic [Width-1:0] out;
  logic             carryout;
  logic             Zero;
  logic             Sign;
  logic             Overflow;

  modport master (
    output enable, A, B, sel,
    input  out, carryout, Zero, Sign, Overflow
  );

  modport slave (
    input  enable, A, B, sel,
    output out, carryout, Zero, Sign, Overflow
  );

endinterface

// File: rtl/alu_64bit_core.sv
// Combinational ALU datapath: result plus carry, zero, sign and overflow flags.
module alu_64bit_core
  import alu_64bit_pkg::*;
(
  input  logic [Width-1:0] a_i,
  input  logic [Width-1:0] b_i,
  input  logic [3:0]       sel_i,
  output logic [Width-1:0] result_o,
  output logic             carry_o,
  output logic             zero_o,
  output logic             sign_o,
  output logic             overflow_o
);

  logic [Width:0]     sum;
  logic [Width:0]     diff;
  logic [2*Width-1:0] prod;
  logic               div_by_zero;

  assign sum         = {1'b0, a_i} + {1'b0, b_i};
  // Bit 64 of the widened difference is the unsigned borrow.
  assign diff        = {1'b0, a_i} - {1'b0, b_i};
  assign prod        = {{Width{1'b0}}, a_i} * {{Width{1'b0}}, b_i};
  assign div_by_zero = (b_i == '0);

  always_comb begin
    result_o   = '0;
    carry_o    = 1'b0;
    overflow_o = 1'b0;
    unique case (sel_i)
      OpAdd: begin
        result_o   = sum[Width-1:0];
        carry_o    = sum[Width];
        overflow_o = (a_i[Width-1] == b_i[Width-1]) && (sum[Width-1] != a_i[Width-1]);
      end
      OpSub: begin
        result_o   = diff[Width-1:0];
        carry_o    = diff[Width];
        overflow_o = (a_i[Width-1] != b_i[Width-1]) && (diff[Width-1] != a_i[Width-1]);
      end
      OpAnd:  result_o = a_i & b_i;
      OpOr:   result_o = a_i | b_i;
      OpXor:  result_o = a_i ^ b_i;
      OpNor:  result_o = ~(a_i | b_i);
      OpNand: result_o = ~(a_i & b_i);
      OpXnor: result_o = ~(a_i ^ b_i);
      OpSll: begin
        result_o = {a_i[Width-2:0], 1'b0};
        carry_o  = a_i[Width-1];
      end
      OpSrl: begin
        result_o = {1'b0, a_i[Width-1:1]};
        carry_o  = a_i[0];
      end
      OpSra: begin
        result_o = {a_i[Width-1], a_i[Width-1:1]};
        carry_o  = a_i[0];
      end
      OpMul: begin
        result_o   = prod[Width-1:0];
        overflow_o = (prod[2*Width-1:Width] != '0);
      end
      OpRol: begin
        result_o = {a_i[Width-2:0], a_i[Width-1]};
        carry_o  = a_i[Width-1];
      end
      OpRor: begin
        result_o = {a_i[0], a_i[Width-1:1]};
        carry_o  = a_i[0];
      end
      OpDiv: begin
        result_o   = div_by_zero ? '1 : (a_i / b_i);
        overflow_o = div_by_zero;
      end
      OpSlt: result_o = ($signed(a_i) < $signed(b_i)) ? Width'(1) : '0;
      default: ;
    endcase
  end

  assign zero_o = (result_o == '0);
  assign sign_o = result_o[Width-1];

endmodule

// File: rtl/alu_64bit.sv
// 64-bit ALU top: registers the core's result and flags on enabled clock edges.
module alu_64bit
  import alu_64bit_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  alu_64bit_if.slave  bus
);

  logic [Width-1:0] result_d, out_q;
  logic             carry_d, zero_d, sign_d, overflow_d;
  logic             carry_q, zero_q, sign_q, overflow_q;

  alu_64bit_core u_core (
    .a_i        (bus.A),
    .b_i        (bus.B),
    .sel_i      (bus.sel),
    .result_o   (result_d),
    .carry_o    (carry_d),
    .zero_o     (zero_d),
    .sign_o     (sign_d),
    .overflow_o (overflow_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q      <= '0;
      carry_q    <= 1'b0;
      zero_q     <= 1'b0;
      sign_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else if (bus.enable) begin
      out_q      <= result_d;
      carry_q    <= carry_d;
      zero_q     <= zero_d;
      sign_q     <= sign_d;
      overflow_q <= overflow_d;
    end
  end

  assign bus.out      = out_q;
  assign bus.carryout = carry_q;
  assign bus.Zero     = zero_q;
  assign bus.Sign     = sign_q;
  assign bus.Overflow = overflow_q;

endmodule

// File: tb/tb_alu_64bit.sv
// Directed self-checking bench for alu_64bit; flags compared as {carryout, Zero, Sign, Overflow}.
module tb_alu_64bit;
  import alu_64bit_pkg::*;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  alu_64bit_if dut_if ();

  alu_64bit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (dut_if.slave)
  );

  initial clk = 1'b1;
  always #5 clk = ~clk;

  logic [3:0] flags;
  assign flags = {dut_if.carryout, dut_if.Zero, dut_if.Sign, dut_if.Overflow};

  task automatic apply(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
    @(negedge clk);
    dut_if.enable = 1'b1;
    dut_if.sel    = op;
    dut_if.A      = a;
    dut_if.B      = b;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n         = 1'b0;
    dut_if.enable = 1'b1;
    dut_if.sel    = OpAdd;
    dut_if.A      = 64'd5;
    dut_if.B      = 64'd7;
    #12;
    checks++;
    if (dut_if.out !== 64'd0) begin
      errors++; $display("FAIL reset_out: got %h want 0", dut_if.out);
    end
    checks++;
    if (flags !== 4'b0000) begin
      errors++; $display("FAIL reset_flags: got %b want 0000", flags);
    end
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (dut_if.out !== 64'd12) begin
      errors++; $display("FAIL reset_first_capture: got %h want %h", dut_if.out, 64'd12);
    end
  endtask

  task automatic test_add;
    apply(OpAdd, 64'd10, 64'd20);
    checks++;
    if (dut_if.out !== 64'd30 || flags !== 4'b0000) begin
      errors++; $display("FAIL add_basic: got %h/%b want %h/0000", dut_if.out, flags, 64'd30);
    end
    apply(OpAdd, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1);
    checks++;
    if (dut_if.out !== 64'h8000_0000_0000_0000 || flags !== 4'b0011) begin
      errors++; $display("FAIL add_ovf: got %h/%b want 8000000000000000/0011", dut_if.out, flags);
    end
    apply(OpAdd, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
    checks++;
    if (dut_if.out !== 64'd0 || flags !== 4'b1100) begin
      errors++; $display("FAIL add_carry: got %h/%b want 0/1100", dut_if.out, flags);
    end
  endtask

  task automatic test_sub;
    apply(OpSub, 64'd50, 64'd30);
    checks++;
    if (dut_if.out !== 64'd20 || flags !== 4'b0000) begin
      errors++; $display("FAIL sub_basic: got %h/%b want %h/0000", dut_if.out, flags, 64'd20);
    end
    apply(OpSub, 64'h8000_0000_0000_0000, 64'd1);
    checks++;
    if (dut_if.out !== 64'h7FFF_FFFF_FFFF_FFFF || flags !== 4'b0001) begin
      errors++; $display("FAIL sub_ovf: got %h/%b want 7fffffffffffffff/0001", dut_if.out, flags);
    end
    apply(OpSub, 64'd30, 64'd50);
    checks++;
    if (dut_if.out !== 64'hFFFF_FFFF_FFFF_FFEC || flags !== 4'b1010) begin
      errors++; $display("FAIL sub_borrow: got %h/%b want ffffffffffffffec/1010", dut_if.out, flags);
    end
  endtask

  // Relies on test_sub leaving 30-50 in the registers.
  task automatic test_hold;
    @(negedge clk);
    dut_if.enable = 1'b0;
    dut_if.sel    = OpAnd;
    dut_if.A      = 64'd0;
    dut_if.B      = 64'd0;
    @(posedge clk);
    #1;
    dut_if.sel = OpDiv;
    dut_if.A   = 64'd9;
    @(posedge clk);
    #1;
    checks++;
    if (dut_if.out !== 64'hFFFF_FFFF_FFFF_FFEC || flags !== 4'b1010) begin
      errors++; $display("FAIL hold: got %h/%b want ffffffffffffffec/1010", dut_if.out, flags);
    end
  endtask

  task automatic test_logic;
    logic [63:0] a, b;
    a = 64'hF0F0_F0F0_F0F0_F0F0;
    b = 64'h0F0F_0F0F_0F0F_0F0F;
    apply(OpAnd, a, b);
    checks++;
    if (dut_if.out !== 64'd0 || flags !== 4'b0100) begin
      errors++; $display("FAIL and: got %h/%b want 0/0100", dut_if.out, flags);
    end
    apply(OpOr, a, b);
    checks++;
    if (dut_if.out !== '1 || flags !== 4'b0010) begin
      errors++; $display("FAIL or: got %h/%b want all-ones/0010", dut_if.out, flags);
    end
    apply(OpXor, a, b);
    checks++;
    if (dut_if.out !== '1 || flags !== 4'b0010) begin
      errors++; $display("FAIL xor: got %h/%b want all-ones/0010", dut_if.out, flags);
    end
    apply(OpNor, a, b);
    checks++;
    if (dut_if.out !== 64'd0 || flags !== 4'b0100) begin
      errors++; $display("FAIL nor: got %h/%b want 0/0100", dut_if.out, flags);
    end
    apply(OpNand, a, b);
    checks++;
    if (dut_if.out !== '1 || flags !== 4'b0010) begin
      errors++; $display("FAIL nand: got %h/%b want all-ones/0010", dut_if.out, flags);
    end
    apply(OpXnor, a, 64'h0F0F_0F0F_0F0F_0F0E);
    checks++;
    if (dut_if.out !== 64'd1 || flags !== 4'b0000) begin
      errors++; $display("FAIL xnor: got %h/%b want 1/0000", dut_if.out, flags);
    end
  endtask

  task automatic test_shift;
    logic [63:0] a;
    a = 64'h8000_0000_0000_0001;
    apply(OpSll, 64'h8000_0000_0000_0000, 64'd0);
    checks++;
    if (dut_if.out !== 64'd0 || flags !== 4'b1100) begin
      errors++; $display("FAIL sll: got %h/%b want 0/1100", dut_if.out, flags);
    end
    apply(OpSrl, a, 64'd0);
    checks++;
    if (dut_if.out !== 64'h4000_0000_0000_0000 || flags !== 4'b1000) begin
      errors++; $display("FAIL srl: got %h/%b want 4000000000000000/1000", dut_if.out, flags);
    end
    apply(OpSra, a, 64'd0);
    checks++;
    if (dut_if.out !== 64'hC000_0000_0000_0000 || flags !== 4'b1010) begin
      errors++; $display("FAIL sra: got %h/%b want c000000000000000/1010", dut_if.out, flags);
    end
    apply(OpRol, a, 64'd0);
    checks++;
    if (dut_if.out !== 64'd3 || flags !== 4'b1000) begin
      errors++; $display("FAIL rol: got %h/%b want 3/1000", dut_if.out, flags);
    end
    apply(OpRor, 64'h0000_0000_0000_0002, 64'd0);
    checks++;
    if (dut_if.out !== 64'd1 || flags !== 4'b0000) begin
      errors++; $display("FAIL ror_even: got %h/%b want 1/0000", dut_if.out, flags);
    end
    apply(OpRor, a, 64'd0);
    checks++;
    if (dut_if.out !== 64'hC000_0000_0000_0000 || flags !== 4'b1010) begin
      errors++; $display("FAIL ror: got %h/%b want c000000000000000/1010", dut_if.out, flags);
    end
  endtask

  task automatic test_mul;
    apply(OpMul, 64'd100, 64'd50);
    checks++;
    if (dut_if.out !== 64'd5000 || flags !== 4'b0000) begin
      errors++; $display("FAIL mul: got %h/%b want %h/0000", dut_if.out, flags, 64'd5000);
    end
    apply(OpMul, 64'h1_0000_0000, 64'h1_0000_0003);
    checks++;
    if (dut_if.out !== 64'h3_0000_0000 || flags !== 4'b0001) begin
      errors++; $display("FAIL mul_ovf: got %h/%b want 300000000/0001", dut_if.out, flags);
    end
  endtask

  task automatic test_div;
    apply(OpDiv, 64'd100, 64'd25);
    checks++;
    if (dut_if.out !== 64'd4 || flags !== 4'b0000) begin
      errors++; $display("FAIL div: got %h/%b want 4/0000", dut_if.out, flags);
    end
    apply(OpDiv, 64'd7, 64'd2);
    checks++;
    if (dut_if.out !== 64'd3 || flags !== 4'b0000) begin
      errors++; $display("FAIL div_trunc: got %h/%b want 3/0000", dut_if.out, flags);
    end
    apply(OpDiv, 64'd100, 64'd0);
    checks++;
    if (dut_if.out !== '1 || flags !== 4'b0011) begin
      errors++; $display("FAIL div_zero: got %h/%b want all-ones/0011", dut_if.out, flags);
    end
  endtask

  task automatic test_slt;
    apply(OpSlt, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
    checks++;
    if (dut_if.out !== 64'd1 || flags !== 4'b0000) begin
      errors++; $display("FAIL slt_true: got %h/%b want 1/0000", dut_if.out, flags);
    end
    apply(OpSlt, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF);
    checks++;
    if (dut_if.out !== 64'd0 || flags !== 4'b0100) begin
      errors++; $display("FAIL slt_false: got %h/%b want 0/0100", dut_if.out, flags);
    end
  endtask

  task automatic test_reset_midop;
    apply(OpOr, 64'hFFFF_0000_0000_0000, 64'd0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (dut_if.out !== 64'd0 || flags !== 4'b0000) begin
      errors++; $display("FAIL reset_async: got %h/%b want 0/0000", dut_if.out, flags);
    end
    #1 rst_n = 1'b1;
    apply(OpAdd, 64'd1, 64'd2);
    checks++;
    if (dut_if.out !== 64'd3 || flags !== 4'b0000) begin
      errors++; $display("FAIL reset_recover: got %h/%b want 3/0000", dut_if.out, flags);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_add();
    test_sub();
    test_hold();
    test_logic();
    test_shift();
    test_mul();
    test_div();
    test_slt();
    test_reset_midop();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
